// File: rtl/weight_fetcher.sv
// weight_fetcher: read-side master for a weight_buffer port.
//
// Turns a (start address, row count) command into one-per-cycle read requests on a
// weight_buffer port, and returns the rows as a valid/ready stream toward the
// systolic-array weight loader. A credit-guarded skid FIFO absorbs the buffer's fixed
// read latency, so downstream backpressure never drops a row.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake; cmd_ready is high only when idle
//   cmd_addr, cmd_rows        first row address, number of rows (saturated to MAX_ROWS)
//   buf_en, buf_addr          weight_buffer read request
//   buf_write_en/_port        tied to zero (read-only master)
//   buf_read_port             weight_buffer read data, READ_LATENCY edges after request
//   out_valid/out_ready       row stream handshake
//   out_data, out_last        row data (byte j at bits [8j+7:8j]), final-row flag
//   done                      one-cycle pulse after the last row handshake
//   perf_stall_cnt            only with WEIGHT_FETCH_PERF_EN defined: saturating count of
//                             cycles with out_valid=1 and out_ready=0, cleared per command
//
// Configuration macro: WEIGHT_FETCH_PERF_EN (adds perf_stall_cnt).

module weight_fetcher #(
  parameter int unsigned MATRIX_WIDTH = 4,
  parameter int unsigned TILE_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = READ_LATENCY + 2,
  parameter int unsigned ADDR_WIDTH   = 8,
  localparam int unsigned MAX_ROWS    = MATRIX_WIDTH * TILE_WIDTH,
  localparam int unsigned ROWS_W      = $clog2(MAX_ROWS + 1),
  localparam int unsigned DATA_W      = MATRIX_WIDTH * 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ROWS_W-1:0]     cmd_rows,
  output logic                  buf_en,
  output logic                  buf_write_en,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [DATA_W-1:0]     buf_write_port,
  input  logic [DATA_W-1:0]     buf_read_port,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  done
`ifdef WEIGHT_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW   = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e                  state_q;
  logic                    buf_en_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ROWS_W-1:0]       rows_q;
  logic [ROWS_W-1:0]       issue_left_q;
  logic [ROWS_W-1:0]       out_cnt_q;
  logic                    done_q;

  // In-flight read tracking: bit 0 set at the edge the buffer samples a request.
  logic [READ_LATENCY-1:0] sr_q, sr_d;

  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]         count_q;

  logic                    push, pop, cmd_fire, can_issue;
  logic [ROWS_W-1:0]       rows_sat;
  logic [TW-1:0]           total;

  assign cmd_ready      = (state_q == StIdle);
  assign cmd_fire       = cmd_valid && cmd_ready;
  assign buf_en         = buf_en_q;
  assign buf_addr       = addr_q;
  assign buf_write_en   = 1'b0;
  assign buf_write_port = '0;
  assign done           = done_q;

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign out_last  = out_valid && (out_cnt_q == rows_q - ROWS_W'(1));

  assign push = sr_q[READ_LATENCY-1];
  assign pop  = out_valid && out_ready;

  assign rows_sat = (cmd_rows > ROWS_W'(MAX_ROWS)) ? ROWS_W'(MAX_ROWS) : cmd_rows;

  // Everything committed to the FIFO: stored rows, the request on the port, and reads
  // in flight. A push only moves an entry from in-flight to stored, so it nets out;
  // this cycle's pop frees a slot immediately.
  always_comb begin
    total = TW'(count_q) + TW'(buf_en_q);
    for (int i = 0; i < READ_LATENCY; i++) begin
      total = total + TW'(sr_q[i]);
    end
    can_issue = (total - TW'(pop)) < TW'(FIFO_DEPTH);
  end

  always_comb begin
    sr_d    = '0;
    sr_d[0] = buf_en_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Control FSM with registered request and done outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      buf_en_q     <= 1'b0;
      addr_q       <= '0;
      rows_q       <= '0;
      issue_left_q <= '0;
      out_cnt_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      buf_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            rows_q    <= rows_sat;
            out_cnt_q <= '0;
            if (rows_sat == '0) begin
              done_q <= 1'b1;
            end else begin
              // The accept edge issues the first read directly.
              buf_en_q     <= 1'b1;
              addr_q       <= cmd_addr;
              issue_left_q <= rows_sat - ROWS_W'(1);
              state_q      <= (rows_sat == ROWS_W'(1)) ? StDrain : StFetch;
            end
          end
        end
        StFetch: begin
          if (can_issue) begin
            buf_en_q     <= 1'b1;
            addr_q       <= addr_q + ADDR_WIDTH'(1);
            issue_left_q <= issue_left_q - ROWS_W'(1);
            if (issue_left_q == ROWS_W'(1)) state_q <= StDrain;
          end
        end
        StDrain: begin
        end
        default: state_q <= StIdle;
      endcase
      if (pop) begin
        out_cnt_q <= out_cnt_q + ROWS_W'(1);
        if (out_last) begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
      end
    end
  end

  // Skid FIFO pointers, occupancy and in-flight shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      sr_q <= sr_d;
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= buf_read_port;
  end

`ifdef WEIGHT_FETCH_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (cmd_fire) begin
      perf_q <= '0;
    end else if (out_valid && !out_ready && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_weight_fetcher.sv
// Directed bench for weight_fetcher with a behavioural two-stage weight_buffer model
// holding row i, byte j = i*j (mod 256).

module tb_weight_fetcher;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [6:0]  cmd_rows;
  logic        buf_en;
  logic        buf_write_en;
  logic [7:0]  buf_addr;
  logic [31:0] buf_write_port;
  logic [31:0] buf_read_port;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;
`ifdef WEIGHT_FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  weight_fetcher dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_rows       (cmd_rows),
    .buf_en         (buf_en),
    .buf_write_en   (buf_write_en),
    .buf_addr       (buf_addr),
    .buf_write_port (buf_write_port),
    .buf_read_port  (buf_read_port),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .done           (done)
`ifdef WEIGHT_FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] row(input int i);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = 8'((i * j) % 256);
    return r;
  endfunction

  // Buffer model: sample at edge N, capture by the fetcher at edge N+2.
  logic [31:0] stage1;
  always @(posedge clk) begin
    if (buf_en) stage1 <= row(int'(buf_addr));
    buf_read_port <= stage1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_cmd(input logic [7:0] a, input logic [6:0] r);
    int w = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rows  = r;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // mode 0: ready high; 1: ready pattern 1-0-0-1; 2: ready low for 10 valid cycles.
  task automatic collect(input string tag, input int n, input int nrows, input int start,
                         input int mode, output int lat, output int span,
                         output int issued, output int maxout);
    int got = 0;
    int cyc = 0;
    int held = 0;
    int first_k = 0;
    int last_k = 0;
    logic [3:0] pat = 4'b1001;
    lat = -1;
    issued = 0;
    maxout = 0;
    while (got < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = pat[cyc % 4];
        default: begin
          if (out_valid && held < 10) begin
            out_ready = 1'b0;
            held++;
          end else begin
            out_ready = (held >= 10);
          end
        end
      endcase
      if (buf_en) issued++;
      if (issued - got > maxout) maxout = issued - got;
      if (out_valid && lat < 0) lat = cyc - 1;
      if (out_valid && out_ready) begin
        check({tag, "_data"}, out_data, row((start + got) % 256));
        check({tag, "_last"}, out_last, (got == nrows - 1));
        if (got == 0) first_k = cyc;
        last_k = cyc;
        got++;
      end
    end
    check({tag, "_rows"}, got, n);
    span = last_k - first_k;
    if (n == nrows) begin
      @(negedge clk);
      check({tag, "_done_hi"}, done, 1);
      check({tag, "_idle_valid"}, out_valid, 0);
      check({tag, "_idle_ready"}, cmd_ready, 1);
      @(negedge clk);
      check({tag, "_done_lo"}, done, 0);
    end
  endtask

  initial begin
    int lat, span, issued, maxout;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_rows  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_buf_en", buf_en, 0);
    check("rst_buf_we", buf_write_en, 0);
    check("rst_buf_wdata", buf_write_port, 0);
    check("rst_done", done, 0);
    check("rst_out_last", out_last, 0);
    rst = 1'b1;

    // 1: 16 rows back-to-back from address 0.
    issue_cmd(8'd0, 7'd16);
    collect("t1", 16, 16, 0, 0, lat, span, issued, maxout);
    check("t1_latency", lat, 3);
    check("t1_span", span, 15);
    check("t1_issued", issued, 16);
    check("t1_outstanding", (maxout <= 4), 1);

    // 2: backpressure pattern.
    issue_cmd(8'd5, 7'd4);
    collect("t2", 4, 4, 5, 1, lat, span, issued, maxout);
    check("t2_issued", issued, 4);
    check("t2_outstanding", (maxout <= 4), 1);

    // 3: address wrap.
    issue_cmd(8'd254, 7'd3);
    collect("t3", 3, 3, 254, 0, lat, span, issued, maxout);
    check("t3_issued", issued, 3);

    // 4: empty command followed by a single row.
    issue_cmd(8'd0, 7'd0);
    @(negedge clk);
    check("t4_zero_done", done, 1);
    check("t4_zero_valid", out_valid, 0);
    check("t4_zero_buf_en", buf_en, 0);
    issue_cmd(8'd7, 7'd1);
    collect("t4", 1, 1, 7, 0, lat, span, issued, maxout);
    check("t4_latency", lat, 3);
    check("t4_issued", issued, 1);

    // 5: reset in the middle of a command.
    issue_cmd(8'd0, 7'd16);
    collect("t5a", 5, 16, 0, 0, lat, span, issued, maxout);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_buf_en", buf_en, 0);
    check("t5_rst_ready", cmd_ready, 1);
    check("t5_rst_last", out_last, 0);
    check("t5_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    issue_cmd(8'd0, 7'd2);
    collect("t5b", 2, 2, 0, 0, lat, span, issued, maxout);
    check("t5_issued", issued, 2);

`ifdef WEIGHT_FETCH_PERF_EN
    // 6: stall counter.
    issue_cmd(8'd0, 7'd4);
    collect("t6", 4, 4, 0, 2, lat, span, issued, maxout);
    check("t6_perf", perf_stall_cnt, 10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
